// File: rtl/fetch_queue.sv
// Two-wide circular instruction buffer between fetch and decode.
// Accepts up to two fetched lanes per cycle and presents the two oldest entries in program order.
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [1:0]              enq_valid,
  input  logic [ADDR_WIDTH-1:0]   enq_addr_0,
  input  logic [ADDR_WIDTH-1:0]   enq_addr_1,
  input  logic [DATA_WIDTH-1:0]   enq_instr_0,
  input  logic [DATA_WIDTH-1:0]   enq_instr_1,
  input  logic                    enq_pred_taken_0,
  input  logic                    enq_pred_taken_1,
  input  logic [ADDR_WIDTH-1:0]   enq_pred_target_0,
  input  logic [ADDR_WIDTH-1:0]   enq_pred_target_1,
  output logic                    enq_ready,
  output logic [1:0]              deq_valid,
  output logic [ADDR_WIDTH-1:0]   deq_addr_0,
  output logic [ADDR_WIDTH-1:0]   deq_addr_1,
  output logic [DATA_WIDTH-1:0]   deq_instr_0,
  output logic [DATA_WIDTH-1:0]   deq_instr_1,
  output logic                    deq_pred_taken_0,
  output logic                    deq_pred_taken_1,
  output logic [ADDR_WIDTH-1:0]   deq_pred_target_0,
  output logic [ADDR_WIDTH-1:0]   deq_pred_target_1,
  input  logic [1:0]              deq_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE     = (PW+1)'(1);
  localparam logic [PW:0] TWO     = (PW+1)'(2);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] instr;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail, head_p1, tail_p1;
  logic [PW:0]   count_q, n_enq, n_deq;
  logic          wr_en_0, wr_en_1;
  entry_t        lane_0, lane_1, wr_entry_0, rd_entry_0, rd_entry_1;

  assign lane_0 = '{addr: enq_addr_0, instr: enq_instr_0,
                    pred_taken: enq_pred_taken_0, pred_target: enq_pred_target_0};
  assign lane_1 = '{addr: enq_addr_1, instr: enq_instr_1,
                    pred_taken: enq_pred_taken_1, pred_target: enq_pred_target_1};

  // All status outputs come from registered count only, never from this cycle's handshakes.
  assign enq_ready = (count_q <= (DEPTH_C - TWO));
  assign deq_valid = {count_q >= TWO, count_q != '0};
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign head_p1   = head + PW'(1);
  assign tail_p1   = tail + PW'(1);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_en_0    = enq_ready && (enq_valid != 2'b00) && !flush;
    wr_en_1    = enq_ready && (enq_valid == 2'b11) && !flush;
    wr_entry_0 = enq_valid[0] ? lane_0 : lane_1;
    n_enq      = (wr_en_0 ? ONE : '0) + (wr_en_1 ? ONE : '0);
    n_deq      = '0;
    // Taking slot 1 without slot 0 is not a legal decode request; it dequeues nothing.
    if (deq_valid[0] && deq_ready[0]) begin
      if (!deq_ready[1])     n_deq = ONE;
      else if (deq_valid[1]) n_deq = TWO;
    end
  end

  // NOTE: storage is deliberately not reset; head, tail and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_0) mem[tail]    <= wr_entry_0;
    if (wr_en_1) mem[tail_p1] <= lane_1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update off the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + n_deq[PW-1:0];
      tail    <= tail + n_enq[PW-1:0];
      count_q <= count_q + n_enq - n_deq;
    end
  end

  always_comb begin
    rd_entry_0 = deq_valid[0] ? mem[head]    : '0;
    rd_entry_1 = deq_valid[1] ? mem[head_p1] : '0;
  end

  assign deq_addr_0        = rd_entry_0.addr;
  assign deq_addr_1        = rd_entry_1.addr;
  assign deq_instr_0       = rd_entry_0.instr;
  assign deq_instr_1       = rd_entry_1.instr;
  assign deq_pred_taken_0  = rd_entry_0.pred_taken;
  assign deq_pred_taken_1  = rd_entry_1.pred_taken;
  assign deq_pred_target_0 = rd_entry_0.pred_target;
  assign deq_pred_target_1 = rd_entry_1.pred_target;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a vector table for occupancy/status plus a
// scoreboard queue that checks every dequeued entry in program order.
module tb_fetch_queue;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] instr;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
  } entry_t;

  typedef struct {
    logic       fl;
    logic [1:0] ev;
    logic [1:0] dr;
    int         exp_count;
    logic [1:0] exp_dv;
    logic       exp_rdy;
  } vec_t;

  logic          clk, rst, flush;
  logic [1:0]    enq_valid, deq_ready, deq_valid;
  logic [AW-1:0] enq_addr_0, enq_addr_1, enq_pred_target_0, enq_pred_target_1;
  logic [DW-1:0] enq_instr_0, enq_instr_1;
  logic          enq_pred_taken_0, enq_pred_taken_1;
  logic          enq_ready, empty, full;
  logic [AW-1:0] deq_addr_0, deq_addr_1, deq_pred_target_0, deq_pred_target_1;
  logic [DW-1:0] deq_instr_0, deq_instr_1;
  logic          deq_pred_taken_0, deq_pred_taken_1;
  logic [$clog2(DEPTH):0] count;

  int     total = 0;
  int     bad = 0;
  entry_t sb[$];
  vec_t   vecs[17];

  fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid),
    .enq_addr_0(enq_addr_0), .enq_addr_1(enq_addr_1),
    .enq_instr_0(enq_instr_0), .enq_instr_1(enq_instr_1),
    .enq_pred_taken_0(enq_pred_taken_0), .enq_pred_taken_1(enq_pred_taken_1),
    .enq_pred_target_0(enq_pred_target_0), .enq_pred_target_1(enq_pred_target_1),
    .enq_ready(enq_ready), .deq_valid(deq_valid),
    .deq_addr_0(deq_addr_0), .deq_addr_1(deq_addr_1),
    .deq_instr_0(deq_instr_0), .deq_instr_1(deq_instr_1),
    .deq_pred_taken_0(deq_pred_taken_0), .deq_pred_taken_1(deq_pred_taken_1),
    .deq_pred_target_0(deq_pred_target_0), .deq_pred_target_1(deq_pred_target_1),
    .deq_ready(deq_ready), .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t slot(input int i);
    entry_t e;
    if (i == 0) e = '{addr: deq_addr_0, instr: deq_instr_0,
                      pred_taken: deq_pred_taken_0, pred_target: deq_pred_target_0};
    else        e = '{addr: deq_addr_1, instr: deq_instr_1,
                      pred_taken: deq_pred_taken_1, pred_target: deq_pred_target_1};
    return e;
  endfunction

  // One clock: drive inputs, pop/compare what decode takes, push what fetch delivers.
  task automatic cycle(input logic fl, input logic [1:0] ev, input logic [1:0] dr,
                       input logic [AW-1:0] base);
    entry_t l0, l1, e;
    int     sz, nd;
    l0.addr = base;       l0.instr = $urandom; l0.pred_taken = 1'($urandom); l0.pred_target = $urandom;
    l1.addr = base + 4;   l1.instr = $urandom; l1.pred_taken = 1'($urandom); l1.pred_target = $urandom;
    flush = fl; enq_valid = ev; deq_ready = dr;
    enq_addr_0 = l0.addr; enq_instr_0 = l0.instr;
    enq_pred_taken_0 = l0.pred_taken; enq_pred_target_0 = l0.pred_target;
    enq_addr_1 = l1.addr; enq_instr_1 = l1.instr;
    enq_pred_taken_1 = l1.pred_taken; enq_pred_target_1 = l1.pred_target;
    sz = sb.size();
    nd = 0;
    if (!fl && sz >= 1 && dr[0]) nd = dr[1] ? ((sz >= 2) ? 2 : 0) : 1;
    for (int i = 0; i < nd; i++) begin
      e = sb.pop_front();
      check($sformatf("deq_slot%0d", i), slot(i), e);
    end
    if (fl) sb.delete();
    else if (sz <= DEPTH - 2) begin
      if (ev[0]) sb.push_back(l0);
      if (ev[1]) sb.push_back(l1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; enq_valid = 2'b00; deq_ready = 2'b00;
  endtask

  // Pulls rst low between edges and checks the outputs clear without a clock.
  task automatic async_reset();
    rst = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_deq_valid", deq_valid, 2'b00);
    check("rst_enq_ready", enq_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_addr0", deq_addr_0, 0);
    #1;
    rst = 1'b1;
    sb.delete();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'b11, 2'b00, 2, 2'b11, 1'b1};
    vecs[1]  = '{1'b0, 2'b11, 2'b00, 4, 2'b11, 1'b1};
    vecs[2]  = '{1'b0, 2'b11, 2'b00, 6, 2'b11, 1'b1};
    vecs[3]  = '{1'b0, 2'b11, 2'b00, 8, 2'b11, 1'b0};
    vecs[4]  = '{1'b0, 2'b11, 2'b00, 8, 2'b11, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 2'b01, 7, 2'b11, 1'b0};
    vecs[6]  = '{1'b0, 2'b11, 2'b01, 6, 2'b11, 1'b1};
    vecs[7]  = '{1'b0, 2'b11, 2'b11, 6, 2'b11, 1'b1};
    vecs[8]  = '{1'b0, 2'b10, 2'b11, 5, 2'b11, 1'b1};
    vecs[9]  = '{1'b0, 2'b01, 2'b10, 6, 2'b11, 1'b1};
    vecs[10] = '{1'b0, 2'b00, 2'b11, 4, 2'b11, 1'b1};
    vecs[11] = '{1'b0, 2'b00, 2'b11, 2, 2'b11, 1'b1};
    vecs[12] = '{1'b0, 2'b00, 2'b11, 0, 2'b00, 1'b1};
    vecs[13] = '{1'b0, 2'b11, 2'b11, 2, 2'b11, 1'b1};
    vecs[14] = '{1'b0, 2'b01, 2'b01, 2, 2'b11, 1'b1};
    vecs[15] = '{1'b0, 2'b00, 2'b01, 1, 2'b01, 1'b1};
    vecs[16] = '{1'b1, 2'b11, 2'b11, 0, 2'b00, 1'b1};

    rst = 1'b0;
    idle_inputs();
    enq_addr_0 = '0; enq_addr_1 = '0; enq_instr_0 = '0; enq_instr_1 = '0;
    enq_pred_taken_0 = 1'b0; enq_pred_taken_1 = 1'b0;
    enq_pred_target_0 = '0; enq_pred_target_1 = '0;
    #2;
    check("init_count", count, 0);
    check("init_deq_valid", deq_valid, 2'b00);
    check("init_enq_ready", enq_ready, 1'b1);
    check("init_empty", empty, 1'b1);
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First enqueue is visible only after its edge.
    check("pre_edge_deq_valid", deq_valid, 2'b00);
    cycle(1'b0, 2'b11, 2'b00, 32'h100);
    check("first_count", count, 2);
    check("first_deq_valid", deq_valid, 2'b11);
    check("first_addr0", deq_addr_0, 32'h100);
    check("first_addr1", deq_addr_1, 32'h104);
    cycle(1'b0, 2'b00, 2'b11, 32'h0);
    check("first_drain", count, 0);

    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].fl, vecs[i].ev, vecs[i].dr, 32'h1000 + 32'(i) * 32'h10);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d_deq_valid", i), deq_valid, vecs[i].exp_dv);
      check($sformatf("vec%0d_enq_ready", i), enq_ready, vecs[i].exp_rdy);
      check($sformatf("vec%0d_full", i), full, vecs[i].exp_count == DEPTH);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_count == 0);
    end

    // Tail at 6 with count 6: simultaneous 2-in/2-out wraps the tail through 7 -> 0.
    async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b11, 2'b00, 32'h2000 + 32'(i) * 32'h10);
    check("wrap_pre_count", count, 6);
    cycle(1'b0, 2'b11, 2'b11, 32'h2100);
    check("wrap_same_cycle_count", count, 6);
    cycle(1'b0, 2'b11, 2'b00, 32'h2200);
    check("wrap_fill_count", count, 8);
    cycle(1'b0, 2'b00, 2'b01, 32'h0);
    check("wrap_single_deq", count, 7);
    cycle(1'b0, 2'b00, 2'b11, 32'h0);
    cycle(1'b0, 2'b00, 2'b11, 32'h0);
    check("wrap_head7_count", count, 3);
    cycle(1'b0, 2'b00, 2'b11, 32'h0);
    check("wrap_drain_count", count, 1);
    cycle(1'b0, 2'b00, 2'b01, 32'h0);

    // Lane 1 alone lands at tail; deq_ready=2'b10 takes nothing.
    cycle(1'b0, 2'b10, 2'b00, 32'h204);
    check("lane1_count", count, 1);
    check("lane1_deq_valid", deq_valid, 2'b01);
    check("lane1_addr0", deq_addr_0, 32'h208);
    check("lane1_slot1_zero", deq_addr_1, 0);
    cycle(1'b0, 2'b00, 2'b10, 32'h0);
    check("ready10_count", count, 1);

    // Flush beats a simultaneous enqueue and dequeue.
    async_reset();
    cycle(1'b0, 2'b11, 2'b00, 32'h3000);
    cycle(1'b0, 2'b11, 2'b00, 32'h3010);
    cycle(1'b0, 2'b01, 2'b00, 32'h3020);
    check("flush_pre_count", count, 5);
    cycle(1'b1, 2'b11, 2'b11, 32'h3030);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1'b1);
    check("flush_deq_valid", deq_valid, 2'b00);
    check("flush_enq_ready", enq_ready, 1'b1);

    // Mid-operation reset, then first enqueue after release.
    cycle(1'b0, 2'b11, 2'b00, 32'h4000);
    cycle(1'b0, 2'b11, 2'b00, 32'h4010);
    check("midrst_pre_count", count, 4);
    async_reset();
    cycle(1'b0, 2'b01, 2'b00, 32'h4100);
    check("post_rst_count", count, 1);
    check("post_rst_addr0", deq_addr_0, 32'h4100);

    // Random traffic with occasional flushes; scoreboard checks order across wraps.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 24) == 0), 2'($urandom), 2'($urandom),
            32'h8000 + 32'(i) * 32'h10);
      check("rand_count", count, sb.size());
      check("rand_deq_valid", deq_valid, {sb.size() >= 2, sb.size() >= 1});
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-wide instruction buffer between instruction fetch and decode. It captures up to two fetched instructions per cycle together with their addresses and BTB prediction bits, and holds them in a circular FIFO. It presents the two oldest entries to decode in program order. Its back-pressure signal stalls fetch, and `flush` discards all buffered wrong-path instructions.

## Interface
- `ADDR_WIDTH`, 32, instruction address width
- `DATA_WIDTH`, 32, instruction word width
- `DEPTH`, 8, entry count; power of two, ≥ 4

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flush`  in  1  discard all entries (branch mispredict or redirect)
- `enq_valid`  in  2  per-lane valid from fetch; bit 0 = lane 0
- `enq_addr_0`, `enq_addr_1`  in  ADDR_WIDTH  lane addresses
- `enq_instr_0`, `enq_instr_1`  in  DATA_WIDTH  lane instructions
- `enq_pred_taken_0`, `enq_pred_taken_1`  in  1  BTB taken prediction per lane
- `enq_pred_target_0`, `enq_pred_target_1`  in  ADDR_WIDTH  BTB target per lane
- `enq_ready`  out  1  high when at least 2 slots are free
- `deq_valid`  out  2  per-slot valid toward decode; only 2'b00, 2'b01 or 2'b11
- `deq_addr_0`, `deq_addr_1`  out  ADDR_WIDTH  head and head+1 address
- `deq_instr_0`, `deq_instr_1`  out  DATA_WIDTH  head and head+1 instruction
- `deq_pred_taken_0`, `deq_pred_taken_1`  out  1  prediction bits
- `deq_pred_target_0`, `deq_pred_target_1`  out  ADDR_WIDTH  prediction targets
- `deq_ready`  in  2  decode accept; bit 1 is honoured only when bit 0 is set
- `count`  out  $clog2(DEPTH)+1  number of occupied entries
- `empty`, `full`  out  1  `count == 0`, `count == DEPTH`

## Operation
- Storage: DEPTH entries, each holding {addr, instr, pred_taken, pred_target}. Head and tail pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `count` is held in a separate register.
- Enqueue:
  - Fires only when `enq_ready` is high.
  - Valid lanes are written compactly in lane order starting at tail:
    - 2'b01 writes lane 0 at tail.
    - 2'b10 writes lane 1 at tail.
    - 2'b11 writes lane 0 at tail and lane 1 at tail+1.
  - `n_enq` = popcount of accepted lanes. Tail advances by `n_enq`.
  - Inputs presented while `enq_ready` is low are ignored. Fetch holds its PC in that case.
- Dequeue:
  - `deq_valid[0]` = (`count` ≥ 1); `deq_valid[1]` = (`count` ≥ 2).
  - Slot 0 shows the head entry; slot 1 shows head+1 (mod DEPTH).
  - `n_deq` = 1 if `deq_valid[0]` & `deq_ready[0]` & ~`deq_ready[1]`.
  - `n_deq` = 2 if `deq_valid[0]` & `deq_ready[0]` & `deq_valid[1]` & `deq_ready[1]`.
  - Otherwise `n_deq` = 0. This includes any cycle where `deq_ready` = 2'b10.
  - Head advances by `n_deq`.
- `enq_ready` = (DEPTH − `count`) ≥ 2, computed from the registered count. A dequeue in the same cycle does not open space until the next cycle.
- Simultaneous enqueue and dequeue: `count_next = count + n_enq − n_deq`. Both pointers update in the same edge.
- Flush: on a rising edge with `flush` high, head, tail and `count` all go to 0. Any enqueue or dequeue in that cycle is discarded; flush has priority.
- Data outputs for any slot whose `deq_valid` bit is low are driven to 0.

## Timing
- Reset (asynchronous, `rst` low):
  - head = tail = `count` = 0
  - `deq_valid` = 2'b00, all `deq_*` data outputs = 0
  - `enq_ready` = 1, `empty` = 1, `full` = 0
  - Storage contents are not reset.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge. The first enqueue after `rst` deasserts is accepted on the first rising edge.
- Enqueue-to-visible latency is 1 cycle: an entry written at edge N appears on `deq_*` after edge N. There is no same-cycle bypass.
- `deq_*`, `count`, `empty`, `full` and `enq_ready` are combinational from registered state only. They have no combinational path from `enq_*`, `deq_ready` or `flush`.
- Wrap-around: writes at tail = DEPTH−1 with 2 lanes place lane 1 at index 0. Slot 1 reads index 0 when head = DEPTH−1.
- At `count` = DEPTH−1, `enq_ready` = 0 even though one slot is free.

## Test plan
- Reset, then enq_valid=2'b11 with addrs 0x100/0x104 at edge 1, deq_ready=0 → after edge 1: count=2, deq_valid=2'b11, deq_addr_0=0x100, deq_addr_1=0x104; before edge 1: deq_valid=0.
- Fill with four 2-wide enqueues and no dequeue (DEPTH=8) → count=8, full=1, enq_ready=0. A fifth enqueue is ignored, and count stays 8 with contents unchanged.
- With count=6, enqueue 2 and dequeue 2 in the same cycle, with tail at 6 → count stays 6 and tail wraps to 0. Slot ordering is preserved across index 7→0.
- Enqueue enq_valid=2'b10 (addr 0x208) into an empty queue → count=1, deq_addr_0=0x208, deq_valid=2'b01. Then deq_ready=2'b10 → n_deq=0 and count stays 1.
- With count=5, assert flush together with enq_valid=2'b11 and deq_ready=2'b11 → count=0, empty=1, deq_valid=0, enq_ready=1 next cycle.
- With count=4, pull `rst` low between clock edges → outputs go to reset values immediately. After release, enq 2'b01 → count=1.
